iec_fast_serial_host: RTL and testbench

//  Host-side (C128) end of the IEC fast-serial/burst link: shifts bytes out on FCLK/DATA
//  for a drive CIA in input SP mode, and shifts bytes in when the drive CIA drives them.

---
 rtl/iec_fast_pkg.sv | 21 ++
 rtl/iec_fast_serial_host_if.sv | 39 +++
 rtl/iec_fast_sync.sv | 36 +++
 rtl/iec_fast_serial_host.sv | 204 ++++++++++++++++++++
 tb/tb_iec_fast_serial_host.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iec_fast_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iec_fast_pkg
//  Description : Shared types and constants for the IEC fast-serial host link.
//  Revision    : 1.0  initial release
// ============================================================================
package iec_fast_pkg;

    // Bits per fast-serial byte; bytes are shifted MSB first.
    localparam int BYTE_BITS = 8;

    // Transmit sequencer states.
    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LOW  = 2'd1,
        TX_HIGH = 2'd2,
        TX_DONE = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/iec_fast_serial_host_if.sv
`default_nettype none
// ============================================================================
//  Module      : iec_fast_serial_host_if
//  Description : Host-core handshake and IEC bus signals of the fast-serial
//                host. master = host core / bus merge, slave = the link.
//  Revision    : 1.0  initial release
// ============================================================================
interface iec_fast_serial_host_if;
    import iec_fast_pkg::*;

    logic                 ce;
    logic                 dir;
    logic [BYTE_BITS-1:0] tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic                 tx_done;
    logic [BYTE_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 rx_overrun;
    logic                 rx_frame_err;
    logic                 iec_data_i;
    logic                 iec_fclk_i;
    logic                 iec_data_o;
    logic                 iec_fclk_o;

    modport master (
        output ce, dir, tx_data, tx_start, rx_ack, iec_data_i, iec_fclk_i,
        input  tx_busy, tx_done, rx_data, rx_valid, rx_overrun, rx_frame_err,
               iec_data_o, iec_fclk_o
    );

    modport slave (
        input  ce, dir, tx_data, tx_start, rx_ack, iec_data_i, iec_fclk_i,
        output tx_busy, tx_done, rx_data, rx_valid, rx_overrun, rx_frame_err,
               iec_data_o, iec_fclk_o
    );
endinterface
`default_nettype wire

// File: rtl/iec_fast_sync.sv
`default_nettype none
// ============================================================================
//  Module      : iec_fast_sync
//  Description : Two-flop synchronizer for an asynchronous bus line plus a
//                clk-domain rising-edge detector.
//  Revision    : 1.0  initial release
// ============================================================================
module iec_fast_sync (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic din,
    output logic      sync,
    output logic      rise
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Resample the line twice, keep one more stage for edge detection; the
    // reset value is the released (high) bus level so reset creates no edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign sync = r_sync;
    assign rise = r_sync & ~r_prev;
endmodule
`default_nettype wire

// File: rtl/iec_fast_serial_host.sv
`default_nettype none
// ============================================================================
//  Module      : iec_fast_serial_host
//  Description : Host end of the IEC fast-serial/burst link. Shifts bytes out
//                on FCLK/DATA (host clocks) and shifts bytes in when the drive
//                clocks FCLK. Replaces the host CIA serial port + timer A.
//  Revision    : 1.0  initial release
// ============================================================================
module iec_fast_serial_host
    import iec_fast_pkg::*;
#(
    parameter int HALF_TICKS = 4,
    parameter int RX_TIMEOUT = 256
) (
    input  wire logic              clk,
    input  wire logic              reset,
    iec_fast_serial_host_if.slave  bus
);
    localparam int HC_W  = $clog2(HALF_TICKS + 1);
    localparam int TO_W  = $clog2(RX_TIMEOUT + 1);
    localparam int BIT_W = $clog2(BYTE_BITS);

    localparam logic [HC_W-1:0]  c_half_last    = HC_W'(HALF_TICKS - 1);
    localparam logic [TO_W-1:0]  c_timeout_last = TO_W'(RX_TIMEOUT - 1);
    localparam logic [BIT_W-1:0] c_bit_msb      = BIT_W'(BYTE_BITS - 1);

    // ---------------------------------------------------------------- TX ---
    tx_state_t              r_state;
    logic [BYTE_BITS-1:0]   r_shreg;
    logic [BIT_W-1:0]       r_bit;
    logic [HC_W-1:0]        r_half;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_data_o;
    logic                   r_fclk_o;

    // Transmit sequencer: FCLK low with the bit on DATA, then FCLK high with
    // the bit held, each for HALF_TICKS ce ticks; dir dropping aborts at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= TX_IDLE;
            r_shreg  <= '0;
            r_bit    <= '0;
            r_half   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_data_o <= 1'b1;
            r_fclk_o <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                TX_IDLE, TX_DONE: begin
                    r_state <= TX_IDLE;
                    if (bus.tx_start && bus.dir) begin
                        r_shreg  <= bus.tx_data;
                        r_bit    <= c_bit_msb;
                        r_half   <= '0;
                        r_busy   <= 1'b1;
                        r_data_o <= bus.tx_data[BYTE_BITS-1];
                        r_fclk_o <= 1'b0;
                        r_state  <= TX_LOW;
                    end
                end
                TX_LOW: begin
                    if (!bus.dir) begin
                        r_state  <= TX_IDLE;
                        r_busy   <= 1'b0;
                        r_half   <= '0;
                        r_data_o <= 1'b1;
                        r_fclk_o <= 1'b1;
                    end else if (bus.ce) begin
                        if (r_half == c_half_last) begin
                            r_half   <= '0;
                            r_fclk_o <= 1'b1;
                            r_state  <= TX_HIGH;
                        end else begin
                            r_half <= r_half + 1'b1;
                        end
                    end
                end
                TX_HIGH: begin
                    if (!bus.dir) begin
                        r_state  <= TX_IDLE;
                        r_busy   <= 1'b0;
                        r_half   <= '0;
                        r_data_o <= 1'b1;
                        r_fclk_o <= 1'b1;
                    end else if (bus.ce) begin
                        if (r_half == c_half_last) begin
                            r_half <= '0;
                            if (r_bit != '0) begin
                                r_bit    <= r_bit - 1'b1;
                                r_data_o <= r_shreg[r_bit - 1'b1];
                                r_fclk_o <= 1'b0;
                                r_state  <= TX_LOW;
                            end else begin
                                r_data_o <= 1'b1;
                                r_done   <= 1'b1;
                                r_busy   <= 1'b0;
                                r_state  <= TX_DONE;
                            end
                        end else begin
                            r_half <= r_half + 1'b1;
                        end
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- RX ---
    logic                   w_fclk_sync_unused;
    logic                   w_fclk_rise;
    logic                   w_data_sync;
    logic                   w_data_rise_unused;
    logic                   w_rx_en;
    logic [BYTE_BITS-1:0]   w_rx_next;

    iec_fast_sync u_sync_fclk (
        .clk   (clk),
        .reset (reset),
        .din   (bus.iec_fclk_i),
        .sync  (w_fclk_sync_unused),
        .rise  (w_fclk_rise)
    );

    iec_fast_sync u_sync_data (
        .clk   (clk),
        .reset (reset),
        .din   (bus.iec_data_i),
        .sync  (w_data_sync),
        .rise  (w_data_rise_unused)
    );

    logic [BIT_W-1:0]       r_rx_cnt;
    logic [TO_W-1:0]        r_rx_timer;
    logic [BYTE_BITS-1:0]   r_rx_shreg;
    logic [BYTE_BITS-1:0]   r_rx_data;
    logic                   r_rx_valid;
    logic                   r_rx_overrun;
    logic                   r_frame_err;

    // The receiver listens only while the drive owns the bus and no byte is
    // being sent; the bit that completes a byte goes straight to rx_data.
    assign w_rx_en   = ~bus.dir & ~r_busy;
    assign w_rx_next = {r_rx_shreg[BYTE_BITS-2:0], w_data_sync};

    // Receive shifter, byte hand-off with overrun detection, and the
    // inter-edge timeout that drops a stalled partial byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_cnt     <= '0;
            r_rx_timer   <= '0;
            r_rx_shreg   <= '0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (bus.rx_ack) begin
                r_rx_valid   <= 1'b0;
                r_rx_overrun <= 1'b0;
            end
            if (!w_rx_en) begin
                r_rx_cnt   <= '0;
                r_rx_timer <= '0;
            end else if (w_fclk_rise) begin
                r_rx_shreg <= w_rx_next;
                r_rx_timer <= '0;
                if (r_rx_cnt == c_bit_msb) begin
                    r_rx_cnt <= '0;
                    if (!r_rx_valid || bus.rx_ack) begin
                        r_rx_data  <= w_rx_next;
                        r_rx_valid <= 1'b1;
                    end else begin
                        r_rx_overrun <= 1'b1;
                    end
                end else begin
                    r_rx_cnt <= r_rx_cnt + 1'b1;
                end
            end else if ((r_rx_cnt != '0) && bus.ce) begin
                if (r_rx_timer == c_timeout_last) begin
                    r_rx_cnt    <= '0;
                    r_rx_timer  <= '0;
                    r_frame_err <= 1'b1;
                end else begin
                    r_rx_timer <= r_rx_timer + 1'b1;
                end
            end
        end
    end

    assign bus.tx_busy      = r_busy;
    assign bus.tx_done      = r_done;
    assign bus.iec_data_o   = r_data_o;
    assign bus.iec_fclk_o   = r_fclk_o;
    assign bus.rx_data      = r_rx_data;
    assign bus.rx_valid     = r_rx_valid;
    assign bus.rx_overrun   = r_rx_overrun;
    assign bus.rx_frame_err = r_frame_err;
endmodule
`default_nettype wire

// File: tb/tb_iec_fast_serial_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iec_fast_serial_host
//  Description : Self-checking bench for iec_fast_serial_host with a
//                behavioural reference model and directed literal checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_iec_fast_serial_host;
    localparam int HALF_TICKS = 4;
    localparam int RX_TIMEOUT = 256;
    localparam int PERIOD     = 2 * HALF_TICKS;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   model_on = 1'b0;

    iec_fast_serial_host_if bus();

    iec_fast_serial_host #(
        .HALF_TICKS (HALF_TICKS),
        .RX_TIMEOUT (RX_TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model -----------------
    bit        m_tx_active = 0;
    int        m_ticks     = 0;
    bit [7:0]  m_byte      = 0;
    bit        m_done      = 0;
    int        m_rx_cnt    = 0;
    int        m_rx_timer  = 0;
    bit [7:0]  m_rx_bits   = 0;
    bit [7:0]  m_rx_data   = 0;
    bit        m_rx_valid  = 0;
    bit        m_rx_ovr    = 0;
    bit        m_ferr      = 0;
    bit        fh[3]       = '{1, 1, 1};   // FCLK input seen 1,2,3 clocks ago
    bit        dh[3]       = '{1, 1, 1};

    // observation of the DUT for directed checks
    bit        tx_bits[$];
    bit        prev_fclk_o = 1;
    int        done_count  = 0;
    int        ferr_count  = 0;
    int        ce_busy     = 0;

    // Compare DUT against the model every cycle, then advance the model with
    // the inputs the DUT will sample on the coming rising edge.
    always @(negedge clk) begin : cmp
        bit       ef, ed, rx_en, rise, d, got;
        int       bi;
        ef = 1; ed = 1;
        if (m_tx_active) begin
            bi = 7 - m_ticks / PERIOD;
            ef = (m_ticks % PERIOD) >= HALF_TICKS;
            ed = m_byte[bi];
        end
        if (model_on) begin
            check("tx_outputs", {bus.tx_busy, bus.tx_done, bus.iec_data_o, bus.iec_fclk_o},
                  {m_tx_active, m_done, ed, ef});
            check("rx_outputs", {bus.rx_valid, bus.rx_overrun, bus.rx_frame_err, bus.rx_data},
                  {m_rx_valid, m_rx_ovr, m_ferr, m_rx_data});
            if (errors > 200) begin
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
        if (!prev_fclk_o && bus.iec_fclk_o) tx_bits.push_back(bus.iec_data_o);
        prev_fclk_o = bus.iec_fclk_o;
        if (bus.tx_done) done_count++;
        if (bus.rx_frame_err) ferr_count++;
        if (bus.ce && bus.tx_busy) ce_busy++;

        if (reset) begin
            m_tx_active = 0; m_ticks = 0; m_done = 0;
            m_rx_cnt = 0; m_rx_timer = 0; m_rx_bits = 0; m_rx_data = 0;
            m_rx_valid = 0; m_rx_ovr = 0; m_ferr = 0;
            fh = '{1, 1, 1}; dh = '{1, 1, 1};
        end else begin
            rx_en = !bus.dir && !m_tx_active;
            rise  = fh[1] && !fh[2];
            d     = dh[1];
            m_done = 0;
            if (m_tx_active) begin
                if (!bus.dir) m_tx_active = 0;
                else if (bus.ce) begin
                    m_ticks++;
                    if (m_ticks == 16 * HALF_TICKS) begin m_tx_active = 0; m_done = 1; end
                end
            end else if (bus.tx_start && bus.dir) begin
                m_tx_active = 1; m_ticks = 0; m_byte = bus.tx_data;
            end
            m_ferr = 0;
            got = 0;
            if (!rx_en) begin
                m_rx_cnt = 0; m_rx_timer = 0;
            end else if (rise) begin
                m_rx_bits = {m_rx_bits[6:0], d};
                m_rx_timer = 0;
                m_rx_cnt++;
                if (m_rx_cnt == 8) begin m_rx_cnt = 0; got = 1; end
            end else if (m_rx_cnt > 0 && bus.ce) begin
                m_rx_timer++;
                if (m_rx_timer == RX_TIMEOUT) begin m_rx_cnt = 0; m_rx_timer = 0; m_ferr = 1; end
            end
            if (bus.rx_ack) m_rx_ovr = 0;
            if (got) begin
                if (!m_rx_valid || bus.rx_ack) begin m_rx_data = m_rx_bits; m_rx_valid = 1; end
                else m_rx_ovr = 1;
            end else if (bus.rx_ack) m_rx_valid = 0;
            fh[2] = fh[1]; fh[1] = fh[0]; fh[0] = bus.iec_fclk_i;
            dh[2] = dh[1]; dh[1] = dh[0]; dh[0] = bus.iec_data_i;
        end
    end

    // ---------------- stimulus helpers -----------------
    task automatic tick();
        @(posedge clk);
        #1;
        bus.ce = !bus.ce && ($urandom_range(0, 1) == 1);
    endtask

    task automatic start_tx(input logic [7:0] b);
        bus.tx_data = b; bus.tx_start = 1;
        tick();
        bus.tx_start = 0;
    endtask

    task automatic wait_done(input int d0, input string nm);
        int n = 0;
        while (done_count == d0 && n < 3000) begin tick(); n++; end
        check({nm, "_done_seen"}, done_count - d0, 1);
    endtask

    function automatic logic [7:0] packed_bits();
        logic [7:0] p = '0;
        for (int i = 0; i < tx_bits.size() && i < 8; i++) p[7 - i] = tx_bits[i];
        return p;
    endfunction

    task automatic drive_bits(input logic [7:0] b, input int n, input bit ack_last);
        for (int i = 7; i > 7 - n; i--) begin
            bus.iec_fclk_i = 0; bus.iec_data_i = b[i];
            repeat ($urandom_range(2, 5)) tick();
            bus.iec_fclk_i = 1;
            if (ack_last && i == 8 - n) begin
                tick(); tick();
                bus.rx_ack = 1;
                tick();
                bus.rx_ack = 0;
                repeat ($urandom_range(2, 4)) tick();
            end else begin
                repeat ($urandom_range(3, 6)) tick();
            end
        end
    endtask

    task automatic ack_pulse();
        bus.rx_ack = 1; tick(); bus.rx_ack = 0; tick();
    endtask

    initial begin : watchdog
        #2_000_000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : main
        int d0, f0, n;
        logic [7:0] b;
        bus.ce = 0; bus.dir = 1; bus.tx_data = 0; bus.tx_start = 0; bus.rx_ack = 0;
        bus.iec_data_i = 1; bus.iec_fclk_i = 1;
        reset = 1;
        tick(); tick();
        model_on = 1;
        tick();
        reset = 0;
        check("rst_busy", bus.tx_busy, 0);
        check("rst_lines", {bus.iec_data_o, bus.iec_fclk_o}, 2'b11);
        check("rst_rx", {bus.rx_valid, bus.rx_overrun, bus.rx_frame_err, bus.rx_data}, 11'h000);

        // 1: transmit A5
        tick();
        tx_bits.delete(); d0 = done_count; ce_busy = 0;
        start_tx(8'hA5);
        check("t1_busy", bus.tx_busy, 1);
        wait_done(d0, "t1");
        tick();
        check("t1_pulses", tx_bits.size(), 8);
        check("t1_bits", packed_bits(), 8'b1010_0101);
        check("t1_ce_ticks", ce_busy, 64);
        check("t1_released", {bus.tx_busy, bus.iec_data_o, bus.iec_fclk_o}, 3'b011);

        // random bytes, with an ignored tx_start while busy
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            tx_bits.delete(); d0 = done_count;
            start_tx(b);
            repeat ($urandom_range(20, 100)) tick();
            bus.tx_data = ~b; bus.tx_start = 1; tick(); bus.tx_start = 0;
            wait_done(d0, "tx_rand");
            tick();
            check("tx_rand_bits", packed_bits(), b);
            check("tx_rand_one_done", done_count - d0, 1);
        end

        // 2: receive 3C then C3 without ack
        bus.dir = 0;
        repeat (4) tick();
        drive_bits(8'h3C, 8, 0);
        drive_bits(8'hC3, 8, 0);
        check("t2_data", bus.rx_data, 8'h3C);
        check("t2_flags", {bus.rx_valid, bus.rx_overrun}, 2'b11);
        ack_pulse();
        check("t2_ack", {bus.rx_valid, bus.rx_overrun}, 2'b00);

        // 3: ack on the completing clock
        drive_bits(8'h12, 8, 0);
        drive_bits(8'h55, 8, 1);
        check("t3_data", bus.rx_data, 8'h55);
        check("t3_flags", {bus.rx_valid, bus.rx_overrun}, 2'b10);
        ack_pulse();

        // 4: partial byte times out, then 81 arrives intact
        f0 = ferr_count;
        drive_bits(8'hE0, 3, 0);
        n = 0;
        while (ferr_count == f0 && n < 3000) begin tick(); n++; end
        check("t4_frame_err", ferr_count - f0, 1);
        repeat (5) tick();
        drive_bits(8'h81, 8, 0);
        check("t4_data", {bus.rx_valid, bus.rx_data}, 9'h181);
        ack_pulse();

        // partial byte discarded silently when dir goes to 1
        f0 = ferr_count;
        drive_bits(8'($urandom), 4, 0);
        bus.dir = 1; repeat (5) tick(); bus.dir = 0;
        repeat (900) tick();
        check("dir_flip_no_ferr", ferr_count - f0, 0);
        drive_bits(8'h3A, 8, 0);
        check("dir_flip_data", bus.rx_data, 8'h3A);

        // random receive traffic with random acknowledges
        for (int k = 0; k < 6; k++) begin
            drive_bits(8'($urandom), 8, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1) ack_pulse();
        end
        ack_pulse();

        // 5: abort FF after 3 bits
        bus.dir = 1; tick();
        tx_bits.delete(); d0 = done_count;
        start_tx(8'hFF);
        n = 0;
        while (tx_bits.size() < 3 && n < 2000) begin tick(); n++; end
        check("t5_three_bits", tx_bits.size(), 3);
        bus.dir = 0;
        tick();
        check("t5_released", {bus.tx_busy, bus.iec_data_o, bus.iec_fclk_o}, 3'b011);
        repeat (300) tick();
        check("t5_no_done", done_count - d0, 0);

        // 6: reset mid-tx and mid-rx
        bus.dir = 1; tick();
        start_tx(8'hC3);
        repeat (30) tick();
        reset = 1; tick(); reset = 0;
        check("t6_tx_reset", {bus.tx_busy, bus.tx_done, bus.iec_data_o, bus.iec_fclk_o}, 4'b0011);
        bus.dir = 0; tick();
        drive_bits(8'h96, 8, 0);
        drive_bits(8'hF0, 4, 0);
        reset = 1; tick(); reset = 0;
        check("t6_rx_reset", {bus.rx_valid, bus.rx_overrun, bus.rx_frame_err, bus.rx_data}, 11'h000);
        tick();
        drive_bits(8'h5A, 8, 0);
        check("t6_after", {bus.rx_valid, bus.rx_data}, 9'h15A);

        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
